// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, instruction-format enum and format decode helpers.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  // Unlisted opcodes fall back to R-type so the packer always produces a word.
  function automatic fmt_e decode_fmt(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_J;
      default:                  return FMT_R;
    endcase
  endfunction

  function automatic logic is_listed(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I packer: scatters register/func fields and the immediate
// into the 32-bit instruction word according to the opcode's format.
module instr_field_packer
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic [31:0] instr
);

  fmt_e fmt;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    fmt   = decode_fmt(opcode);
    instr = '0;
    case (fmt)
      FMT_I: begin
        // Immediate shifts carry func7 in the upper slot and a 5-bit shamt.
        if (opcode == OP_IMM && (func3 == 3'b001 || func3 == 3'b101))
          instr = {func7, imm[4:0], rs1, func3, rd, opcode};
        else
          instr = {imm[11:0], rs1, func3, rd, opcode};
      end
      FMT_S:   instr = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U:   instr = {imm[31:12], rd, opcode};
      FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = {func7, rs2, rs1, func3, rd, opcode};
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field tuples into words, tags them with a
// running address and queues them in a DEPTH-entry buffer.
// Optional feature macro: ENCODER_ILLEGAL_CHECK_EN (adds err, drops unlisted opcodes).
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr
`ifdef ENCODER_ILLEGAL_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   packed_word;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_addr  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   addr_q;
  logic          accept;
  logic          push;
  logic          pop;

  instr_field_packer u_packer (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .func3  (in_func3),
    .func7  (in_func7),
    .imm    (in_imm),
    .instr  (packed_word)
  );

  assign accept = in_valid && in_ready;

`ifdef ENCODER_ILLEGAL_CHECK_EN
  logic listed;
  assign listed = is_listed(in_opcode);
  assign push   = accept && listed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= accept && !listed;
  end
`else
  assign push = accept;
`endif

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // in_ready is a flop fed from next occupancy: no combinational path from
  // out_ready, so a pop while full only frees the slot for the next cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_q   <= BASE_ADDR;
      in_ready <= 1'b0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next < FULL);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        addr_q <= addr_q + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: buffer storage has no reset; stale entries are masked by out_valid below.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= packed_word;
      mem_addr[wr_ptr]  <= addr_q;
    end
  end

  assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;

endmodule
